// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, buffered
// MDU results fill idle slots, and a starvation counter forces an MDU slot.
module wb_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_RegWriteW,
  input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic [DATA_WIDTH-1:0]     i_ResultW,
  input  logic                      i_MduValid,
  input  logic [REG_ADDR_WIDTH-1:0] i_MduDst,
  input  logic [DATA_WIDTH-1:0]     i_MduData,
  output logic                      o_MduReady,
  input  logic [REG_ADDR_WIDTH-1:0] i_RsD,
  input  logic [REG_ADDR_WIDTH-1:0] i_RtD,
  output logic                      o_PendHazardD,
  output logic                      o_StallW,
  output logic                      o_RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] o_WriteReg,
  output logic [DATA_WIDTH-1:0]     o_WriteData
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_WIDTH-1:0] dst_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [3:0]                starve_cnt;

  logic empty;
  logic full;
  logic force_grant;
  logic mdu_grant;
  logic accept;
  logic push;
  logic pop;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign force_grant = !empty && (starve_cnt == 4'(STARVE_LIMIT));
  assign mdu_grant   = !empty && (!i_RegWriteW || force_grant);
  assign accept      = i_MduValid && !full;
  // Results targeting r0 complete the handshake but are never stored.
  assign push        = accept && (i_MduDst != '0);
  assign pop         = mdu_grant;

  assign o_MduReady  = !full;
  assign o_StallW    = force_grant && i_RegWriteW;
  assign o_RegWrite  = mdu_grant ? 1'b1          : i_RegWriteW;
  assign o_WriteReg  = mdu_grant ? dst_q[rd_ptr]  : i_WriteRegW;
  assign o_WriteData = mdu_grant ? data_q[rd_ptr] : i_ResultW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr]  <= i_MduDst;
      data_q[wr_ptr] <= i_MduData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (mdu_grant || empty) begin
      starve_cnt <= '0;
    end else if (i_RegWriteW && (starve_cnt != 4'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] offs;
    offs          = '0;
    o_PendHazardD = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if ({1'b0, offs} < count) begin
        if ((i_RsD != '0) && (dst_q[i] == i_RsD)) o_PendHazardD = 1'b1;
        if ((i_RtD != '0) && (dst_q[i] == i_RtD)) o_PendHazardD = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst_n;
  logic          rw;
  logic [AW-1:0] wreg;
  logic [DW-1:0] res;
  logic          mv;
  logic [AW-1:0] mdst;
  logic [DW-1:0] mdata;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic          o_ready;
  logic          o_hz;
  logic          o_stall;
  logic          o_rw;
  logic [AW-1:0] o_wreg;
  logic [DW-1:0] o_wdata;

  int n_vec = 0;
  int n_err = 0;

  wb_port_arbiter #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_RegWriteW(rw), .i_WriteRegW(wreg), .i_ResultW(res),
    .i_MduValid(mv), .i_MduDst(mdst), .i_MduData(mdata),
    .o_MduReady(o_ready),
    .i_RsD(rs), .i_RtD(rt),
    .o_PendHazardD(o_hz), .o_StallW(o_stall),
    .o_RegWrite(o_rw), .o_WriteReg(o_wreg), .o_WriteData(o_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue of buffered results plus a starvation tally.
  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } ent_t;
  ent_t mq[$];
  int   m_starve = 0;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] wreg;
    logic [DW-1:0] res;
    logic          mv;
    logic [AW-1:0] mdst;
    logic [DW-1:0] mdata;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          e_ready;
    logic          e_stall;
    logic          e_hz;
    logic          e_rw;
    logic [AW-1:0] e_wreg;
    logic [DW-1:0] e_wdata;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic a_rw, input logic [AW-1:0] a_wreg, input logic [DW-1:0] a_res,
                        input logic a_mv, input logic [AW-1:0] a_mdst, input logic [DW-1:0] a_mdata,
                        input logic [AW-1:0] a_rs, input logic [AW-1:0] a_rt);
    rw = a_rw; wreg = a_wreg; res = a_res;
    mv = a_mv; mdst = a_mdst; mdata = a_mdata;
    rs = a_rs; rt = a_rt;
  endtask

  task automatic check_model(input string tag);
    logic e_full, e_empty, e_force, e_grant, e_hz;
    e_empty = (mq.size() == 0);
    e_full  = (mq.size() == DEPTH);
    e_force = !e_empty && (m_starve == LIMIT);
    e_grant = !e_empty && (!rw || e_force);
    e_hz    = 1'b0;
    foreach (mq[k]) begin
      if (rs != 0 && mq[k].dst == rs) e_hz = 1'b1;
      if (rt != 0 && mq[k].dst == rt) e_hz = 1'b1;
    end
    chk({tag, ".ready"}, 32'(o_ready), 32'(!e_full));
    chk({tag, ".stall"}, 32'(o_stall), 32'(e_force && rw));
    chk({tag, ".hazard"}, 32'(o_hz), 32'(e_hz));
    chk({tag, ".regwrite"}, 32'(o_rw), 32'(e_grant ? 1'b1 : rw));
    chk({tag, ".wreg"}, 32'(o_wreg), 32'(e_grant ? mq[0].dst : wreg));
    chk({tag, ".wdata"}, o_wdata, e_grant ? mq[0].data : res);
  endtask

  // Advance one clock; the model follows the same input values the DUT samples.
  task automatic tick();
    logic was_empty, grant, can_push;
    @(posedge clk);
    if (rst_n) begin
      was_empty = (mq.size() == 0);
      can_push  = (mq.size() < DEPTH);
      grant     = !was_empty && (!rw || (m_starve == LIMIT));
      if (grant) void'(mq.pop_front());
      if (mv && can_push && mdst != 0) mq.push_back('{dst: mdst, data: mdata});
      if (grant || was_empty) m_starve = 0;
      else if (rw && m_starve < LIMIT) m_starve = m_starve + 1;
    end
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[5]  = '{1'b1, 5'd9,  32'hAAAA, 1'b1, 5'd7, 32'h77,       5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  32'hAAAA};
    vecs[6]  = '{1'b1, 5'd10, 32'hBBBB, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hBBBB};
    vecs[7]  = '{1'b1, 5'd11, 32'hCCCC, 1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'hCCCC};
    vecs[8]  = '{1'b1, 5'd12, 32'hDDDD, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'hDDDD};
    vecs[9]  = '{1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h1313};
    vecs[10] = '{1'b1, 5'd14, 32'hEEEE, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  32'h77};
    vecs[11] = '{1'b1, 5'd14, 32'hEEEE, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 32'hEEEE};

    rst_n = 1'b0;
    set_in(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    chk("reset.ready", 32'(o_ready), 32'd1);
    chk("reset.stall", 32'(o_stall), 32'd0);
    chk("reset.hazard", 32'(o_hz), 32'd0);
    chk("reset.regwrite", 32'(o_rw), 32'd1);
    chk("reset.wreg", 32'(o_wreg), 32'd3);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rw, vecs[i].wreg, vecs[i].res, vecs[i].mv, vecs[i].mdst, vecs[i].mdata,
             vecs[i].rs, vecs[i].rt);
      @(negedge clk);
      chk($sformatf("vec%0d.ready", i), 32'(o_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d.stall", i), 32'(o_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d.hazard", i), 32'(o_hz), 32'(vecs[i].e_hz));
      chk($sformatf("vec%0d.regwrite", i), 32'(o_rw), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d.wreg", i), 32'(o_wreg), 32'(vecs[i].e_wreg));
      chk($sformatf("vec%0d.wdata", i), o_wdata, vecs[i].e_wdata);
      tick();
    end

    // Fill the FIFO under a busy pipeline, then drain in order.
    set_in(1'b1, 5'd20, 32'h2020, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
    @(negedge clk); chk("full.push1_ready", 32'(o_ready), 32'd1); check_model("full1"); tick();
    set_in(1'b1, 5'd21, 32'h2121, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    @(negedge clk); chk("full.push2_ready", 32'(o_ready), 32'd1); check_model("full2"); tick();
    set_in(1'b1, 5'd22, 32'h2222, 1'b1, 5'd6, 32'h66, 5'd3, 5'd4);
    @(negedge clk); chk("full.blocked_ready", 32'(o_ready), 32'd0);
    chk("full.hazard", 32'(o_hz), 32'd1); check_model("full3"); tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    @(negedge clk); chk("full.pop_ready", 32'(o_ready), 32'd0);
    chk("full.pop1_wreg", 32'(o_wreg), 32'd3); chk("full.pop1_wdata", o_wdata, 32'h33);
    check_model("full4"); tick();
    set_in(1'b1, 5'd23, 32'h2323, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    @(negedge clk); chk("full.reopen_ready", 32'(o_ready), 32'd1);
    chk("full.pass_wreg", 32'(o_wreg), 32'd23); check_model("full5"); tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk); chk("full.pop2_wreg", 32'(o_wreg), 32'd4); chk("full.pop2_wdata", o_wdata, 32'h44);
    check_model("full6"); tick();
    @(negedge clk); chk("full.pop3_wreg", 32'(o_wreg), 32'd6); chk("full.pop3_wdata", o_wdata, 32'h66);
    check_model("full7"); tick();
    @(negedge clk); chk("full.drained", 32'(o_rw), 32'd0); check_model("full8"); tick();

    // Reset with two entries buffered and the starvation count at 3.
    set_in(1'b1, 5'd24, 32'h2424, 1'b1, 5'd8, 32'h88, 5'd0, 5'd0); tick();
    set_in(1'b1, 5'd24, 32'h2424, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0); tick();
    set_in(1'b1, 5'd24, 32'h2424, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); tick();
    tick();
    set_in(1'b1, 5'd25, 32'h2525, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
    @(negedge clk); chk("rst_mid.pre_ready", 32'(o_ready), 32'd0);
    chk("rst_mid.pre_hazard", 32'(o_hz), 32'd1); check_model("rst_mid_pre");
    #1 rst_n = 1'b0;
    #1;
    mq.delete();
    m_starve = 0;
    chk("rst_mid.ready", 32'(o_ready), 32'd1);
    chk("rst_mid.stall", 32'(o_stall), 32'd0);
    chk("rst_mid.hazard", 32'(o_hz), 32'd0);
    chk("rst_mid.regwrite", 32'(o_rw), 32'd1);
    chk("rst_mid.wreg", 32'(o_wreg), 32'd25);
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 5'd26, 32'h2626, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); check_model($sformatf("post_rst%0d", c)); tick();
      mv = 1'b0;
    end

    for (int c = 0; c < 800; c++) begin
      set_in($urandom_range(0, 99) < 65, AW'($urandom), $urandom,
             $urandom_range(0, 99) < 50, AW'($urandom_range(0, 7)), $urandom,
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      @(negedge clk);
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
